serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-shares one existing fulladd cell over WIDTH clock cycles to add two WIDTH-bit operands.
- Latches operands on a start request and shifts them LSB-first through the fulladd.
- Keeps the carry in a flip-flop between bits and assembles the result in a shift register.
- Sits between a requesting master and the fulladd datapath; it is the sequencer for that cell.

Parameters:
WIDTH, 8, operand/result width in bits (legal 2..32)

Ports:
clk  input  1  single clock, all flops rising-edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request; accepted only when state is IDLE
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
cin  input  1  carry-in, sampled on the accepting edge
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  registered result, held until next accepted start
cout  output  1  registered final carry, held with sum

Behaviour:
- Reset: one clock, one synchronous active-low reset; rst_n low at a rising edge forces the following, from any state including mid-RUN:
  - state=IDLE, bit counter=0, carry flop=0
  - sum=0, cout=0, busy=0, done=0
  - operand shift registers cleared
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at edge E0 → load a/b into shift regs, carry flop←cin, counter←0, clear sum/cout, go RUN.
  - start=0 → stay IDLE.
- RUN, each edge:
  - fulladd inputs X=a_sr[0], Y=b_sr[0], Cin=carry flop.
  - Sum bit shifts into sum from the MSB side; carry flop←Cout; a_sr/b_sr shift right; counter++.
  - At the edge where counter==WIDTH-1 → go DONE; cout←final Cout.
  - RUN therefore spans edges E1..E_WIDTH.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE.
  - start is ignored in DONE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after acceptance. Minimum start-to-start spacing is WIDTH+2 cycles.
- busy=1 only in RUN; start during RUN or DONE is ignored and does not queue; a, b and cin are don't-care outside the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- sum/cout are stable from done until the next accepted start (then cleared at E0). Intermediate sum bits are visible during RUN; consumers use only the done-qualified values.
- Counter width is clog2(WIDTH), computed by constant localparam; wrap is never reached because the exit happens at WIDTH-1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared header (serial_add_defs.vh):
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH
- Sub-module: exactly one instance of the existing fulladd, connected by port order (X, Y, Cin, Sum, Cout).
- Counter, shift registers and FSM live in serial_add_ctrl itself.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start 1 cycle → busy for 8 cycles; done pulse 9 edges after accept; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start held high continuously with a=0x01, b=0x02 → accepted only from IDLE; done pulses every 10 cycles with sum=0x03. Operands changed during RUN do not affect the result.
- Reset mid-RUN (rst_n low at 4th RUN edge) → next cycle busy=0, done=0, sum=0, cout=0, state IDLE. A subsequent a=0x10, b=0x20 gives sum=0x30.
- Start asserted exactly in the DONE cycle → ignored (no busy next cycle); re-asserted one cycle later → accepted. Previous sum is held until then.
- Random self-checking: 1000 random a/b/cin at WIDTH=8 and WIDTH=16 → {cout,sum} equals the reference a+b+cin at every done; done is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// Single-bit full adder cell, time-shared by the serial add sequencer.
module fulladd
   import serial_add_ctrl_pkg::*;
(
   input  logic X,
   input  logic Y,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = X ^ Y ^ Cin;
   assign Cout = (X & Y) | (X & Cin) | (Y & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first
// through one fulladd cell, keeping the carry in a flop between bits.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic             w_sum;
   logic             w_cout;

   fulladd u_fa (r_a_sr[0], r_b_sr[0], r_carry, w_sum, w_cout);

   // Sequencer: accept in IDLE, one bit per edge in RUN, one-cycle DONE pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  sum     <= '0;
                  cout    <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
               sum     <= {w_sum, sum[WIDTH-1:1]};
               r_carry <= w_cout;
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               if (r_cnt == LAST) begin
                  cout    <= w_cout;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
